// File: rtl/gpio_bus_master_if.sv
// gpio_bus_master_if
// Command/response handshake and GPIO strobe signals for gpio_bus_master.
// The shared tri-state data bus is a plain inout port on the master module
// and is not part of this interface.
//
// Signals:
//   cmd_valid, cmd_write, cmd_wdata : command offered by the controller
//   cmd_ready                       : master can accept a command
//   rsp_valid, rsp_rdata            : captured read data, held until accepted
//   rsp_ready                       : response consumer accepts
//   bus_w_en, bus_r_en, bus_add     : peripheral strobes and address select
//
// Modports:
//   master : the gpio_bus_master side
//   slave  : the controller / peripheral side
interface gpio_bus_master_if #(
  parameter int DW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          bus_w_en;
  logic          bus_r_en;
  logic          bus_add;

  modport master (
    input  cmd_valid, cmd_write, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, bus_w_en, bus_r_en, bus_add
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, bus_w_en, bus_r_en, bus_add
  );
endinterface

// File: rtl/gpio_bus_master.sv
// gpio_bus_master
// Converts single-beat read/write commands into GPIO peripheral bus cycles
// (r_en / w_en / add / bidirectional data) and returns read data on a
// response handshake. Owns the master side of the tri-state data bus.
//
// Optional feature: define GPIO_MASTER_POLL_EN to build an idle-time poller
// that reads the pins every POLL_PERIOD idle cycles and reports changes.
//
// Ports:
//   clk          : clock, rising edge
//   reset        : synchronous, active-high
//   bus          : handshake + strobes (gpio_bus_master_if.master)
//   bus_data     : shared tri-state data bus, driven only while writing
//   busy         : state is not IDLE
//   poll_value   : last polled pin value (0 without the poller)
//   poll_changed : one-cycle pulse when a poll sees a new value
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a command (or a poll); cmd_ready high
// WR      | w_en/add high, data driven, held for HOLD_CYCLES cycles
// RD_CAP  | r_en/add high, peripheral samples its pins
// RD_XFER | r_en high, add low, peripheral drives data; captured here
// RSP     | rsp_valid high until rsp_ready
module gpio_bus_master #(
  parameter int DW          = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int POLL_PERIOD = 64
) (
  input  logic                clk,
  input  logic                reset,
  gpio_bus_master_if.master   bus,
  inout  wire  [DW-1:0]       bus_data,
  output logic                busy,
  output logic [DW-1:0]       poll_value,
  output logic                poll_changed
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_CAP  = 3'd2,
    RD_XFER = 3'd3,
    RSP     = 3'd4
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] wr_data;
  logic [7:0]    hold_cnt;
  logic          accept;
  logic          poll_start;
  logic          poll_active;

  assign accept = bus.cmd_valid && bus.cmd_ready;

  // Output enable comes from the state register only: no path from any
  // input to the bus, and RD_XFER can never be followed by WR.
  assign bus_data = (state == WR) ? wr_data : {DW{1'bz}};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = bus.cmd_write ? WR : RD_CAP;
        end else if (poll_start) begin
          state_nxt = RD_CAP;
        end
      end
      WR:      if (hold_cnt == 8'd0) state_nxt = IDLE;
      RD_CAP:  state_nxt = RD_XFER;
      RD_XFER: state_nxt = poll_active ? IDLE : RSP;
      RSP:     if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state register without any decode glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wr_data       <= '0;
      hold_cnt      <= '0;
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.bus_w_en  <= 1'b0;
      bus.bus_r_en  <= 1'b0;
      bus.bus_add   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && accept) begin
        wr_data <= bus.cmd_wdata;
      end

      // Down-counter: loaded with HOLD_CYCLES-1, WR ends at terminal count 0.
      if (state == IDLE && accept && bus.cmd_write) begin
        hold_cnt <= HOLD_LOAD;
      end else if (state == WR && hold_cnt != 8'd0) begin
        hold_cnt <= hold_cnt - 8'd1;
      end

      if (state == RD_XFER && !poll_active) begin
        bus.rsp_rdata <= bus_data;
      end

      bus.cmd_ready <= (state_nxt == IDLE);
      busy          <= (state_nxt != IDLE);
      bus.rsp_valid <= (state_nxt == RSP);
      bus.bus_w_en  <= (state_nxt == WR);
      bus.bus_r_en  <= (state_nxt == RD_CAP) || (state_nxt == RD_XFER);
      bus.bus_add   <= (state_nxt == WR) || (state_nxt == RD_CAP);
    end
  end

`ifdef GPIO_MASTER_POLL_EN
  localparam int PCW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [PCW-1:0] POLL_TC = PCW'(POLL_PERIOD - 1);

  logic [PCW-1:0] poll_cnt;

  // A pending command always wins; the counter then sits at its terminal
  // value and the poll launches on the first idle cycle with no command.
  assign poll_start = (state == IDLE) && !bus.cmd_valid && (poll_cnt == POLL_TC);

  always_ff @(posedge clk) begin
    if (reset) begin
      poll_cnt     <= '0;
      poll_active  <= 1'b0;
      poll_value   <= '0;
      poll_changed <= 1'b0;
    end else begin
      poll_changed <= 1'b0;

      if (poll_start) begin
        poll_cnt <= '0;
      end else if (state == IDLE && !bus.cmd_valid && poll_cnt != POLL_TC) begin
        poll_cnt <= poll_cnt + 1'b1;
      end

      if (poll_start) begin
        poll_active <= 1'b1;
      end else if (state == RD_XFER) begin
        poll_active <= 1'b0;
      end

      if (state == RD_XFER && poll_active && bus_data != poll_value) begin
        poll_value   <= bus_data;
        poll_changed <= 1'b1;
      end
    end
  end
`else
  assign poll_start   = 1'b0;
  assign poll_active  = 1'b0;
  assign poll_value   = '0;
  assign poll_changed = 1'b0;
`endif

endmodule
